// File: rtl/fifo_scoreboard_pkg.sv
// Shared types and defaults for the FIFO scoreboard checker.
package fifo_scoreboard_pkg;

  // Default width of the push/pop/mismatch event counters.
  localparam int unsigned CNT_W_DEFAULT = 32;

  // What happened to the popped word in a given cycle.
  typedef enum logic [1:0] {
    CMP_NONE,
    CMP_MATCH,
    CMP_MISMATCH,
    CMP_UNDERFLOW
  } cmp_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + {{(W-1){1'b0}}, 1'b1};
  endfunction

  // Next count: clear wins over increment; increment saturates.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_inc) begin
      count_d = sat_inc(count_q);
    end
  end

  // Count register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/fifo_scoreboard.sv
// In-bench checker for a single-clock FIFO-like DUT: mirrors accepted words
// in an expected queue and compares every delivered word against its head.
module fifo_scoreboard
  import fifo_scoreboard_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = CNT_W_DEFAULT,
  parameter int BYPASS = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cg,
  input  logic                     i_clear,
  input  logic                     i_pushValid,
  input  logic [WIDTH-1:0]         i_pushData,
  input  logic                     i_popValid,
  input  logic [WIDTH-1:0]         i_popData,
  output logic [$clog2(DEPTH):0]   o_occupancy,
  output logic [CNT_W-1:0]         o_nPushed,
  output logic [CNT_W-1:0]         o_nPopped,
  output logic [CNT_W-1:0]         o_nMismatch,
  output logic                     o_mismatchValid,
  output logic [WIDTH-1:0]         o_mismatchExpected,
  output logic [WIDTH-1:0]         o_mismatchActual,
  output logic                     o_errMismatch,
  output logic                     o_errUnderflow,
  output logic                     o_errOverflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam bit BYP = (BYPASS != 0);

  // Expected-word storage; contents are meaningless outside [rptr, wptr).
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    occ_q, occ_d;
  logic             mv_q, mv_d;
  logic [WIDTH-1:0] mexp_q, mexp_d;
  logic [WIDTH-1:0] mact_q, mact_d;
  logic             err_mis_q, err_mis_d;
  logic             err_und_q, err_und_d;
  logic             err_ovf_q, err_ovf_d;

  logic             push_ev, pop_ev, clr;
  logic             empty, full;
  logic             bypass_hit, do_read, do_write, overflow;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] cmp_exp;
  cmp_e             outcome;

  // The clock gate qualifies every event and the synchronous clear alike.
  assign push_ev = i_cg & i_pushValid;
  assign pop_ev  = i_cg & i_popValid;
  assign clr     = i_cg & i_clear;

  // MSB differs with equal low bits -> full; identical pointers -> empty.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head  = mem_q[rptr_q[AW-1:0]];

  // Decide this cycle's queue actions and compare outcome from pre-cycle state.
  always_comb begin
    bypass_hit = BYP && push_ev && pop_ev && empty;
    do_read    = pop_ev && !empty;
    // A pop in the same cycle frees the slot, so a push into a full queue is legal then.
    do_write   = push_ev && !bypass_hit && (!full || do_read);
    overflow   = push_ev && full && !do_read;
    cmp_exp    = head;
    outcome    = CMP_NONE;
    if (bypass_hit) begin
      cmp_exp = i_pushData;
      outcome = (i_popData == i_pushData) ? CMP_MATCH : CMP_MISMATCH;
    end else if (do_read) begin
      outcome = (i_popData == head) ? CMP_MATCH : CMP_MISMATCH;
    end else if (pop_ev) begin
      outcome = CMP_UNDERFLOW;
    end
  end

  // Next-state for pointers, occupancy, mismatch capture and sticky flags.
  always_comb begin
    wptr_d    = wptr_q + (do_write ? PW'(1) : PW'(0));
    rptr_d    = rptr_q + (do_read  ? PW'(1) : PW'(0));
    mv_d      = 1'b0;
    mexp_d    = mexp_q;
    mact_d    = mact_q;
    err_mis_d = err_mis_q;
    err_und_d = err_und_q | (outcome == CMP_UNDERFLOW);
    err_ovf_d = err_ovf_q | overflow;
    if (outcome == CMP_MISMATCH) begin
      mv_d      = 1'b1;
      mexp_d    = cmp_exp;
      mact_d    = i_popData;
      err_mis_d = 1'b1;
    end
    if (clr) begin
      wptr_d    = '0;
      rptr_d    = '0;
      mv_d      = 1'b0;
      mexp_d    = '0;
      mact_d    = '0;
      err_mis_d = 1'b0;
      err_und_d = 1'b0;
      err_ovf_d = 1'b0;
    end
    occ_d = wptr_d - rptr_d;
  end

  // Control and reported-state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      occ_q     <= '0;
      mv_q      <= 1'b0;
      mexp_q    <= '0;
      mact_q    <= '0;
      err_mis_q <= 1'b0;
      err_und_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      occ_q     <= occ_d;
      mv_q      <= mv_d;
      mexp_q    <= mexp_d;
      mact_q    <= mact_d;
      err_mis_q <= err_mis_d;
      err_und_q <= err_und_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  // Queue storage write; no reset needed since the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (do_write) begin
      mem_q[wptr_q[AW-1:0]] <= i_pushData;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_push (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (clr),
    .i_inc   (push_ev),
    .o_count (o_nPushed)
  );

  sat_counter #(.W(CNT_W)) u_cnt_pop (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (clr),
    .i_inc   (pop_ev),
    .o_count (o_nPopped)
  );

  sat_counter #(.W(CNT_W)) u_cnt_mis (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (clr),
    .i_inc   (outcome == CMP_MISMATCH),
    .o_count (o_nMismatch)
  );

  assign o_occupancy        = occ_q;
  assign o_mismatchValid    = mv_q;
  assign o_mismatchExpected = mexp_q;
  assign o_mismatchActual   = mact_q;
  assign o_errMismatch      = err_mis_q;
  assign o_errUnderflow     = err_und_q;
  assign o_errOverflow      = err_ovf_q;

endmodule

// File: tb/tb_fifo_scoreboard.sv
// Bench for fifo_scoreboard: one instance without and one with bypass,
// driven by shared stimulus and checked against a behavioural model.
module tb_fifo_scoreboard;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int CW = 8;

  logic         clk = 1'b0;
  logic         rst, cg, clr, pv, ppv;
  logic [W-1:0] pd, ppd;

  logic [4:0]    occ0, occ1;
  logic [CW-1:0] np0, np1, npo0, npo1, nm0, nm1;
  logic          mv0, mv1, em0, em1, eu0, eu1, eo0, eo1;
  logic [W-1:0]  me0, me1, ma0, ma1;

  always #5 clk = ~clk;

  fifo_scoreboard #(.WIDTH(W), .DEPTH(D), .CNT_W(CW), .BYPASS(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_clear(clr),
    .i_pushValid(pv), .i_pushData(pd), .i_popValid(ppv), .i_popData(ppd),
    .o_occupancy(occ0), .o_nPushed(np0), .o_nPopped(npo0), .o_nMismatch(nm0),
    .o_mismatchValid(mv0), .o_mismatchExpected(me0), .o_mismatchActual(ma0),
    .o_errMismatch(em0), .o_errUnderflow(eu0), .o_errOverflow(eo0)
  );

  fifo_scoreboard #(.WIDTH(W), .DEPTH(D), .CNT_W(CW), .BYPASS(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_clear(clr),
    .i_pushValid(pv), .i_pushData(pd), .i_popValid(ppv), .i_popData(ppd),
    .o_occupancy(occ1), .o_nPushed(np1), .o_nPopped(npo1), .o_nMismatch(nm1),
    .o_mismatchValid(mv1), .o_mismatchExpected(me1), .o_mismatchActual(ma1),
    .o_errMismatch(em1), .o_errUnderflow(eu1), .o_errOverflow(eo1)
  );

  typedef struct {
    logic [31:0] occ, npush, npop, nmis, mv, mexp, mact, em, eu, eo;
  } snap_t;

  int    nvec = 0;
  int    nerr = 0;
  snap_t ms [2];
  logic [W-1:0] mbuf [2][D];
  int    mhead [2];
  int    mcnt  [2];
  snap_t eq0 [$];
  snap_t eq1 [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v >= 32'((1 << CW) - 1)) ? v : v + 32'd1;
  endfunction

  task automatic model_clear(input int b);
    ms[b]    = '{default: 32'd0};
    mhead[b] = 0;
    mcnt[b]  = 0;
  endtask

  // Behavioural model of one cycle for the instance with bypass = b.
  task automatic model_step(input int b);
    bit           do_cmp;
    logic [W-1:0] dexp;
    do_cmp   = 1'b0;
    dexp     = '0;
    ms[b].mv = 32'd0;
    if (cg) begin
      if (clr) begin
        model_clear(b);
      end else begin
        if (pv && ppv && mcnt[b] == 0 && b == 1) begin
          do_cmp = 1'b1;
          dexp   = pd;
        end else begin
          if (ppv) begin
            if (mcnt[b] > 0) begin
              do_cmp   = 1'b1;
              dexp     = mbuf[b][mhead[b]];
              mhead[b] = (mhead[b] + 1) % D;
              mcnt[b]  = mcnt[b] - 1;
            end else begin
              ms[b].eu = 32'd1;
            end
          end
          if (pv) begin
            if (mcnt[b] < D) begin
              mbuf[b][(mhead[b] + mcnt[b]) % D] = pd;
              mcnt[b] = mcnt[b] + 1;
            end else begin
              ms[b].eo = 32'd1;
            end
          end
        end
        if (pv)  ms[b].npush = sat(ms[b].npush);
        if (ppv) ms[b].npop  = sat(ms[b].npop);
        if (do_cmp && dexp != ppd) begin
          ms[b].mv   = 32'd1;
          ms[b].mexp = 32'(dexp);
          ms[b].mact = 32'(ppd);
          ms[b].em   = 32'd1;
          ms[b].nmis = sat(ms[b].nmis);
        end
        ms[b].occ = 32'(mcnt[b]);
      end
    end
  endtask

  function automatic snap_t act(input int b);
    snap_t s;
    if (b == 0) begin
      s = '{occ: 32'(occ0), npush: 32'(np0), npop: 32'(npo0), nmis: 32'(nm0),
            mv: 32'(mv0), mexp: 32'(me0), mact: 32'(ma0),
            em: 32'(em0), eu: 32'(eu0), eo: 32'(eo0)};
    end else begin
      s = '{occ: 32'(occ1), npush: 32'(np1), npop: 32'(npo1), nmis: 32'(nm1),
            mv: 32'(mv1), mexp: 32'(me1), mact: 32'(ma1),
            em: 32'(em1), eu: 32'(eu1), eo: 32'(eo1)};
    end
    return s;
  endfunction

  task automatic cmp_snap(input string p, input snap_t a, input snap_t e);
    chk({p, "occ"},   a.occ,   e.occ);
    chk({p, "npush"}, a.npush, e.npush);
    chk({p, "npop"},  a.npop,  e.npop);
    chk({p, "nmis"},  a.nmis,  e.nmis);
    chk({p, "mv"},    a.mv,    e.mv);
    chk({p, "mexp"},  a.mexp,  e.mexp);
    chk({p, "mact"},  a.mact,  e.mact);
    chk({p, "em"},    a.em,    e.em);
    chk({p, "eu"},    a.eu,    e.eu);
    chk({p, "eo"},    a.eo,    e.eo);
  endtask

  // Drive one cycle, queue the model's expectation, then check after the edge.
  task automatic cycle(input bit c, input bit cl, input bit pvv, input logic [W-1:0] pdd,
                       input bit ppvv, input logic [W-1:0] ppdd);
    cg = c; clr = cl; pv = pvv; pd = pdd; ppv = ppvv; ppd = ppdd;
    model_step(0); eq0.push_back(ms[0]);
    model_step(1); eq1.push_back(ms[1]);
    @(posedge clk); #1;
    if (eq0.size() == 0) chk("sb0.empty", 32'd1, 32'd0);
    else cmp_snap("d0.", act(0), eq0.pop_front());
    if (eq1.size() == 0) chk("sb1.empty", 32'd1, 32'd0);
    else cmp_snap("d1.", act(1), eq1.pop_front());
  endtask

  task automatic push(input logic [W-1:0] d);  cycle(1, 0, 1, d, 0, '0); endtask
  task automatic pop(input logic [W-1:0] d);   cycle(1, 0, 0, '0, 1, d); endtask
  task automatic idle();                       cycle(1, 0, 0, '0, 0, '0); endtask
  task automatic do_clear();                   cycle(1, 1, 0, '0, 0, '0); endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r;
    rst = 1'b1; cg = 1'b1; clr = 1'b0; pv = 1'b0; ppv = 1'b0; pd = '0; ppd = '0;
    model_clear(0); model_clear(1);
    repeat (2) @(posedge clk);
    #1;
    cmp_snap("rst0.", act(0), ms[0]);
    cmp_snap("rst1.", act(1), ms[1]);
    rst = 1'b0;
    repeat (10) idle();

    // In-order traffic.
    push(8'h11); push(8'h22); push(8'h33);
    pop(8'h11);  pop(8'h22);  pop(8'h33);
    chk("order.occ", 32'(occ0), 32'd0);
    chk("order.np",  32'(np0),  32'd3);

    // Mismatch capture, then sticky flag survives clean traffic.
    push(8'hA5); pop(8'h5A);
    chk("mm.mv",  32'(mv0), 32'd1);
    chk("mm.exp", 32'(me0), 32'hA5);
    chk("mm.act", 32'(ma0), 32'h5A);
    push(8'h01); pop(8'h01); idle();
    chk("mm.sticky", 32'(em0), 32'd1);
    chk("mm.pulse",  32'(mv0), 32'd0);

    // Pop while empty.
    do_clear();
    pop(8'h00);
    chk("und.eu",   32'(eu0),  32'd1);
    chk("und.npop", 32'(npo0), 32'd1);

    // Overflow: 17th word dropped, then 16 clean pops.
    do_clear();
    for (int i = 0; i < 17; i++) push(8'(i));
    chk("ovf.occ", 32'(occ0), 32'd16);
    chk("ovf.eo",  32'(eo0),  32'd1);
    chk("ovf.np",  32'(np0),  32'd17);
    // Push + pop while full is legal.
    cycle(1, 0, 1, 8'hC3, 1, 8'h00);
    chk("full.pp.eo", 32'(occ0), 32'd16);
    for (int i = 1; i < 16; i++) pop(8'(i));
    pop(8'hC3);
    chk("ovf.nm", 32'(nm0), 32'd0);
    chk("ovf.empty", 32'(occ0), 32'd0);

    // Push + pop while empty: bypass vs. no bypass.
    do_clear();
    cycle(1, 0, 1, 8'h7E, 1, 8'h7E);
    chk("byp1.eu",  32'(eu1),  32'd0);
    chk("byp1.occ", 32'(occ1), 32'd0);
    chk("byp0.eu",  32'(eu0),  32'd1);
    chk("byp0.occ", 32'(occ0), 32'd1);
    cycle(1, 0, 1, 8'h10, 1, 8'h11);

    // Clock gate low ignores events; clear wins over same-cycle events.
    do_clear();
    cycle(0, 0, 1, 8'h44, 1, 8'h44);
    cycle(0, 1, 1, 8'h45, 0, 8'h00);
    for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
    cycle(1, 1, 1, 8'h99, 1, 8'h12);
    chk("clr.occ", 32'(occ0), 32'd0);
    chk("clr.np",  32'(np0),  32'd0);

    // Counter saturation.
    for (int i = 0; i < 260; i++) pop(8'h00);
    chk("sat.npop", 32'(npo0), 32'hFF);
    do_clear();
    for (int i = 0; i < 260; i++) push(8'(i));
    chk("sat.npush", 32'(np0), 32'hFF);

    // Random traffic, mostly correct data.
    do_clear();
    for (int i = 0; i < 400; i++) begin
      logic c, a, b, k;
      c = ($urandom_range(7) != 0);
      a = $urandom_range(1);
      b = $urandom_range(1);
      k = ($urandom_range(63) == 0);
      r = 8'($urandom);
      if (mcnt[0] > 0 && $urandom_range(7) != 0) cycle(c, k, a, r, b, mbuf[0][mhead[0]]);
      else if ($urandom_range(1) == 0)           cycle(c, k, a, r, b, r);
      else                                       cycle(c, k, a, r, b, 8'($urandom));
    end

    // Asynchronous reset mid-operation discards queued words.
    do_clear();
    push(8'h21); push(8'h22); push(8'h23);
    rst = 1'b1;
    #1;
    model_clear(0); model_clear(1);
    cmp_snap("arst0.", act(0), ms[0]);
    cmp_snap("arst1.", act(1), ms[1]);
    @(posedge clk); #1;
    rst = 1'b0;
    pop(8'h21);
    chk("arst.eu", 32'(eu0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fifo_scoreboard.md
Name: fifo_scoreboard

Overview:
Synthesisable in-bench checker that sits directly downstream of a FIFO-like DUT in the fifo scoreboard benches. It consumes the DUT's qualified push events (wcg && wvalid && wready) and pop events (rcg && rvalid && rready). It keeps an internal expected-data queue, compares each popped word against the queue head, and exposes counters plus sticky error flags. This replaces post-sim log diffing for single-clock DUTs.

Parameters:
WIDTH, 8, data width of checked words.
DEPTH, 16, expected-queue capacity; power of 2, >=2.
CNT_W, 32, width of the event counters.
BYPASS, 0, 1 = DUT may pop a word in the same cycle it is pushed while empty (zero-latency passthrough).

Ports:
i_clk  input  1  clock; the DUT write/read clock.
i_rst  input  1  asynchronous, active-high reset.
i_cg  input  1  clockgate; when 0, no state changes and events are ignored.
i_clear  input  1  synchronous clear; same effect as reset.
i_pushValid  input  1  DUT accepted a word this cycle.
i_pushData  input  WIDTH  word accepted by DUT.
i_popValid  input  1  DUT delivered a word this cycle.
i_popData  input  WIDTH  word delivered by DUT.
o_occupancy  output  $clog2(DEPTH)+1  expected-queue entries.
o_nPushed  output  CNT_W  saturating push count.
o_nPopped  output  CNT_W  saturating pop count.
o_nMismatch  output  CNT_W  saturating mismatch count.
o_mismatchValid  output  1  one-cycle pulse: the last checked pop mismatched.
o_mismatchExpected  output  WIDTH  expected word of the latest mismatch.
o_mismatchActual  output  WIDTH  actual word of the latest mismatch.
o_errMismatch  output  1  sticky: any mismatch seen.
o_errUnderflow  output  1  sticky: pop with no expected word.
o_errOverflow  output  1  sticky: push while queue full.

Behaviour:
- Reset and i_clear: all outputs 0, queue empty, wptr = rptr = 0. i_clear takes priority over events in the same cycle. Reset mid-operation discards the queue contents.
- All outputs are registered. An event in cycle N is reflected in the outputs at cycle N+1.
- Queue: circular buffer of flops with wptr/rptr of $clog2(DEPTH)+1 bits. The MSB distinguishes full from empty. Pointers wrap modulo 2*DEPTH. occupancy = wptr - rptr.
- An event counts only when i_cg = 1. Cycle outcome, evaluated on pre-cycle state:
  - push only, not full: write i_pushData at wptr; wptr+1.
  - push only, full: word dropped; errOverflow <= 1; wptr unchanged.
  - pop only, not empty: compare i_popData to mem[rptr]; rptr+1.
  - pop only, empty: errUnderflow <= 1; no compare; rptr unchanged.
  - push + pop, not empty: both proceed. Full is allowed here because the pop frees the slot.
  - push + pop, empty, BYPASS=1: compare i_popData to i_pushData; queue unchanged.
  - push + pop, empty, BYPASS=0: push is written; errUnderflow <= 1; no compare.
- Compare: on inequality, o_mismatchValid pulses for 1 cycle, expected/actual are latched and held until the next mismatch, errMismatch <= 1, and nMismatch+1.
- nPushed and nPopped increment on every counted event, including dropped and underflowed ones.
- All counters saturate at all-ones and never wrap.
- Sticky flags clear only on reset or i_clear.

Decomposition:
- Package fifo_scoreboard_pkg: compare-outcome enum {CMP_NONE, CMP_MATCH, CMP_MISMATCH, CMP_UNDERFLOW} and the default CNT_W constant.
- One sub-module: sat_counter (parameter W; inputs i_clk, i_rst, i_clear, i_inc; output o_count), instanced 3 times.
- Queue, pointers and compare stay in fifo_scoreboard.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, occupancy 0.
- Push 0x11, 0x22, 0x33, then pop 0x11, 0x22, 0x33 -> nPushed=3, nPopped=3, nMismatch=0, no errors, occupancy returns to 0.
- Push 0xA5, pop 0x5A -> next cycle mismatchValid=1, expected=0xA5, actual=0x5A, errMismatch=1 and stays 1 after further matching traffic.
- Pop while empty (no push) -> errUnderflow=1, nPopped=1, nMismatch=0, occupancy 0.
- DEPTH=16: push 17 words with no pops -> occupancy 16, errOverflow=1, nPushed=17. Then 16 pops of words 0..15 are clean; the 17th word is never expected.
- BYPASS=1: push+pop of 0x7E while empty -> no error, occupancy 0. With BYPASS=0, the same stimulus gives errUnderflow=1 and occupancy 1.
- Event with i_cg=0 -> no counter change. Assert i_clear with occupancy 5 -> everything 0 next cycle.
